sub_seq: RTL and testbench

- Multi-cycle subtractor for the CPU datapath; the inverse operation to the combinational adder.
- Computes sub_rd = rs1 - rs2 over N/W cycles, W bits per cycle, LSB chunk first, with a ripple borrow held in a register between cycles.
- Uses valid/ready handshakes on input and output so the execute stage can stall it.
- Produces difference, borrow-out, zero and signed-overflow flags.

---
 rtl/sub_pkg.sv | 21 ++
 rtl/sub_chunk.sv | 19 +
 rtl/sub_seq.sv | 137 +++++++++++++
 tb/tb_sub_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared state type and sizing helpers for the chunked sequential subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    function automatic int chunk_count(input int n, input int w);
        return n / w;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n, input int w);
        int c;
        c = $clog2(n / w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// One W-bit slice of a ripple-borrow subtractor: {bout, d} = a - b - bin.
module sub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    // The extra top bit goes negative exactly when a borrow is needed.
    logic [W:0] diff;

    assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign d    = diff[W-1:0];
    assign bout = diff[W];

endmodule

// File: rtl/sub_seq.sv
// Multi-cycle subtractor: rs1 - rs2 over N/W cycles, LSB chunk first, with a
// registered ripple borrow between cycles and valid/ready on both sides.
module sub_seq
    import sub_pkg::*;
#(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sub_rd,
    output logic         bo,
    output logic         zero,
    output logic         ovf,
    output logic [1:0]   state_o
);

    localparam int NCH = chunk_count(N, W);
    localparam int CW  = cnt_width(N, W);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    if (W < 1 || N % W != 0) begin : g_bad_width
        $error("sub_seq: W must be positive and divide N");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // input side is ready only in IDLE, the output side is valid only in DONE.

    sub_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  res_q, res_d;
    logic          bo_q, bo_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;

    logic [31:0]   base;
    logic [W-1:0]  a_chunk;
    logic [W-1:0]  b_chunk;
    logic [W-1:0]  d_chunk;
    logic          b_out;

    assign base    = 32'(cnt_q) * 32'(W);
    assign a_chunk = a_q[base +: W];
    assign b_chunk = b_q[base +: W];

    sub_chunk #(.W(W)) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .bin  (borrow_q),
        .d    (d_chunk),
        .bout (b_out)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bo_d     = bo_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = rs1;
                    b_d      = rs2;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                res_d[base +: W] = d_chunk;
                borrow_d         = b_out;
                cnt_d            = cnt_q + CW'(1);
                // Flags are latched from the completed result so DONE sees them settled.
                if (cnt_q == LAST) begin
                    bo_d    = b_out;
                    zero_d  = (res_d == '0);
                    ovf_d   = (a_q[N-1] != b_q[N-1]) && (res_d[N-1] != a_q[N-1]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bo_q     <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bo_q     <= bo_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sub_rd    = res_q;
    assign bo        = bo_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sub_seq.sv
// Bench for sub_seq: directed cases and randomized traffic at W=4 and W=16,
// scored against an arithmetic model of subtraction and its flags.
module tb_sub_seq;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [N-1:0] rs1       [2];
    logic [N-1:0] rs2       [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [N-1:0] sub_rd    [2];
    logic         bo        [2];
    logic         zero      [2];
    logic         ovf       [2];
    logic [1:0]   state     [2];

    int           checks = 0;
    int           errors = 0;
    int           nch [2] = '{4, 1};
    logic [18:0]  exp_q [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sub_seq #(.N(N), .W(4)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .rs1(rs1[0]), .rs2(rs2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sub_rd(sub_rd[0]), .bo(bo[0]), .zero(zero[0]), .ovf(ovf[0]),
        .state_o(state[0])
    );

    sub_seq #(.N(N), .W(16)) u_w16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .rs1(rs1[1]), .rs2(rs2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sub_rd(sub_rd[1]), .bo(bo[1]), .zero(zero[1]), .ovf(ovf[1]),
        .state_o(state[1])
    );

    // ---------------- checking and model ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected word {difference, borrow, zero, overflow} from plain integer arithmetic.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, d, sd;
        logic [15:0] rd;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        d  = ua - ub;
        sd = sa - sb;
        rd = d[15:0];
        return {rd, ua < ub, rd == 16'd0, (sd > 32767) || (sd < -32768)};
    endfunction

    function automatic logic [18:0] obs(input int w);
        return {sub_rd[w], bo[w], zero[w], ovf[w]};
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic [18:0] e);
        int n;
        n = 0;
        while (!in_ready[w] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready[w]), 32'd1);
        in_valid[w] = 1'b1;
        rs1[w]      = a;
        rs2[w]      = b;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid[w] = 1'b0;
        rs1[w]      = 16'($urandom);
        rs2[w]      = 16'($urandom);
    endtask

    task automatic wait_result(input int w);
        int lat;
        lat = 0;
        while (!out_valid[w] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(nch[w]));
    endtask

    task automatic receive(input int w, input bit rand_ready);
        logic [18:0] e;
        int n;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        check("out_valid", 32'(out_valid[w]), 32'd1);
        check("busy_ready", 32'(in_ready[w]), 32'd0);
        check("result", 32'(obs(w)), 32'(e));
        n = 0;
        while (rand_ready && $urandom_range(0, 2) == 0 && n < 8) begin
            out_ready[w] = 1'b0;
            @(negedge clk);
            n++;
            check("stall_result", 32'(obs(w)), 32'(e));
            check("stall_valid", 32'(out_valid[w]), 32'd1);
        end
        out_ready[w] = 1'b1;
        @(negedge clk);
        out_ready[w] = 1'b0;
        check("valid_drop", 32'(out_valid[w]), 32'd0);
        check("ready_back", 32'(in_ready[w]), 32'd1);
        check("idle_hold", 32'(obs(w)), 32'(e));
    endtask

    task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic [18:0] e, input bit rand_ready);
        send(w, a, b, e);
        wait_result(w);
        receive(w, rand_ready);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [18:0] e;
        logic [15:0] a, b;
        rst_n = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid[w]  = 1'b0;
            out_ready[w] = 1'b0;
            rs1[w]       = '0;
            rs2[w]       = '0;
        end
        #1;
        for (int w = 0; w < 2; w++) begin
            check("rst_ready", 32'(in_ready[w]), 32'd1);
            check("rst_valid", 32'(out_valid[w]), 32'd0);
            check("rst_outputs", 32'(obs(w)), 32'd0);
            check("rst_state", 32'(state[w]), 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases on both widths.
        for (int w = 0; w < 2; w++) begin
            do_op(w, 16'h0005, 16'h0003, {16'h0002, 3'b000}, 1'b0);
            do_op(w, 16'h0003, 16'h0005, {16'hFFFE, 3'b100}, 1'b0);
            do_op(w, 16'h1000, 16'h0001, {16'h0FFF, 3'b000}, 1'b0);
            do_op(w, 16'h8000, 16'h0001, {16'h7FFF, 3'b001}, 1'b0);
            do_op(w, 16'h1234, 16'h1234, {16'h0000, 3'b010}, 1'b0);
        end

        // Back-pressure with ignored input pulses while DONE.
        send(0, 16'h00FF, 16'h000F, {16'h00F0, 3'b000});
        wait_result(0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
        for (int i = 0; i < 10; i++) begin
            out_ready[0] = 1'b0;
            in_valid[0]  = i[0];
            rs1[0]       = 16'($urandom);
            rs2[0]       = 16'($urandom);
            check("bp_valid", 32'(out_valid[0]), 32'd1);
            check("bp_ready", 32'(in_ready[0]), 32'd0);
            check("bp_result", 32'(obs(0)), 32'(e));
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_drop", 32'(out_valid[0]), 32'd0);
        check("bp_ready_back", 32'(in_ready[0]), 32'd1);
        repeat (3) @(negedge clk);
        check("bp_no_phantom", 32'(out_valid[0]), 32'd0);
        check("bp_still_idle", 32'(state[0]), 32'd0);

        // Reset in the middle of RUN.
        send(0, 16'hABCD, 16'h1111, {16'h9ABC, 3'b000});
        @(negedge clk);
        check("mid_run_state", 32'(state[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_state", 32'(state[0]), 32'd0);
        check("abort_ready", 32'(in_ready[0]), 32'd1);
        check("abort_valid", 32'(out_valid[0]), 32'd0);
        check("abort_outputs", 32'(obs(0)), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(out_valid[0]), 32'd0);
        do_op(0, 16'h0010, 16'h0001, {16'h000F, 3'b000}, 1'b0);

        // Randomized traffic at each width.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1000; i++) begin
                a = 16'($urandom);
                b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_op(w, a, b, model(a, b), 1'b1);
            end
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
